// File: rtl/ysyx_040750_mem_arbiter.sv
// rtl/ysyx_040750_mem_arbiter.sv - shares the data-memory bus between the IF fetch and MEM load/store requesters
// MEM has priority; a saturating starvation counter forces an IF grant once IF has waited STARVE_MAX grants.
module ysyx_040750_mem_arbiter #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 64,
  parameter int          STARVE_MAX = 4,
  parameter logic [8:0]  IF_RSTRB   = 9'h00F
) (
  input  logic              I_sys_clk,
  input  logic              I_rst,
  input  logic              I_if_rd_en,
  input  logic [ADDR_W-1:0] I_if_addr,
  output logic              O_if_ready,
  output logic              O_if_rvalid,
  output logic [DATA_W-1:0] O_if_rdata,
  input  logic              I_mem_rd_en,
  input  logic              I_mem_wr_en,
  input  logic [ADDR_W-1:0] I_mem_addr,
  input  logic [DATA_W-1:0] I_mem_wdata,
  input  logic [7:0]        I_mem_wstrb,
  input  logic [8:0]        I_mem_rstrb,
  output logic              O_mem_ready,
  output logic              O_mem_rvalid,
  output logic              O_mem_bvalid,
  output logic [DATA_W-1:0] O_mem_rdata,
  output logic              O_bus_rd_en,
  output logic              O_bus_wr_en,
  output logic [ADDR_W-1:0] O_bus_addr,
  output logic [DATA_W-1:0] O_bus_wdata,
  output logic [7:0]        O_bus_wstrb,
  output logic [8:0]        O_bus_rstrb,
  input  logic              I_bus_ready,
  input  logic              I_bus_rvalid,
  input  logic [DATA_W-1:0] I_bus_rdata,
  input  logic              I_bus_bvalid
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

  state_t            state, state_nxt;
  logic              own_if;
  logic              op_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [7:0]        lat_wstrb;
  logic [8:0]        lat_rstrb;
  logic [CNT_W-1:0]  starve_cnt;

  logic mem_req, any_req, grant_if, resp_done;

  assign mem_req   = I_mem_rd_en | I_mem_wr_en;
  assign any_req   = mem_req | I_if_rd_en;
  assign grant_if  = I_if_rd_en & (~mem_req | (starve_cnt == CNT_W'(STARVE_MAX)));
  // Only the response type matching the latched op completes the transaction.
  assign resp_done = op_wr ? I_bus_bvalid : I_bus_rvalid;

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state      <= S_IDLE;
      own_if     <= 1'b0;
      op_wr      <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
      lat_rstrb  <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_req) begin
        own_if    <= grant_if;
        op_wr     <= ~grant_if & I_mem_wr_en;
        lat_addr  <= grant_if ? I_if_addr : I_mem_addr;
        lat_wdata <= grant_if ? '0 : I_mem_wdata;
        lat_wstrb <= grant_if ? '0 : I_mem_wstrb;
        lat_rstrb <= grant_if ? IF_RSTRB : I_mem_rstrb;
        if (grant_if)
          starve_cnt <= '0;
        else if (I_if_rd_en && starve_cnt != CNT_W'(STARVE_MAX))
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req)     state_nxt = S_ADDR;
      S_ADDR:  if (I_bus_ready) state_nxt = S_RESP;
      S_RESP:  if (resp_done)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    O_if_ready   = 1'b0;
    O_if_rvalid  = 1'b0;
    O_if_rdata   = '0;
    O_mem_ready  = 1'b0;
    O_mem_rvalid = 1'b0;
    O_mem_bvalid = 1'b0;
    O_mem_rdata  = '0;
    O_bus_rd_en  = 1'b0;
    O_bus_wr_en  = 1'b0;
    O_bus_addr   = '0;
    O_bus_wdata  = '0;
    O_bus_wstrb  = '0;
    O_bus_rstrb  = '0;
    case (state)
      S_ADDR: begin
        O_bus_rd_en = ~op_wr;
        O_bus_wr_en = op_wr;
        O_bus_addr  = lat_addr;
        O_bus_wdata = lat_wdata;
        O_bus_wstrb = lat_wstrb;
        O_bus_rstrb = lat_rstrb;
        O_if_ready  = I_bus_ready & own_if;
        O_mem_ready = I_bus_ready & ~own_if;
      end
      S_RESP: begin
        if (!op_wr && I_bus_rvalid) begin
          if (own_if) begin
            O_if_rvalid = 1'b1;
            O_if_rdata  = I_bus_rdata;
          end else begin
            O_mem_rvalid = 1'b1;
            O_mem_rdata  = I_bus_rdata;
          end
        end
        O_mem_bvalid = op_wr & I_bus_bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_040750_mem_arbiter.sv
// tb/tb_ysyx_040750_mem_arbiter.sv - directed self-checking bench for the IF/MEM bus arbiter
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_ysyx_040750_mem_arbiter;

  logic        I_sys_clk, I_rst;
  logic        I_if_rd_en;
  logic [31:0] I_if_addr;
  logic        O_if_ready, O_if_rvalid;
  logic [63:0] O_if_rdata;
  logic        I_mem_rd_en, I_mem_wr_en;
  logic [31:0] I_mem_addr;
  logic [63:0] I_mem_wdata;
  logic [7:0]  I_mem_wstrb;
  logic [8:0]  I_mem_rstrb;
  logic        O_mem_ready, O_mem_rvalid, O_mem_bvalid;
  logic [63:0] O_mem_rdata;
  logic        O_bus_rd_en, O_bus_wr_en;
  logic [31:0] O_bus_addr;
  logic [63:0] O_bus_wdata;
  logic [7:0]  O_bus_wstrb;
  logic [8:0]  O_bus_rstrb;
  logic        I_bus_ready, I_bus_rvalid, I_bus_bvalid;
  logic [63:0] I_bus_rdata;

  int checks   = 0;
  int failures = 0;

  ysyx_040750_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_MAX(4), .IF_RSTRB(9'h00F)) dut (
    .I_sys_clk(I_sys_clk), .I_rst(I_rst),
    .I_if_rd_en(I_if_rd_en), .I_if_addr(I_if_addr),
    .O_if_ready(O_if_ready), .O_if_rvalid(O_if_rvalid), .O_if_rdata(O_if_rdata),
    .I_mem_rd_en(I_mem_rd_en), .I_mem_wr_en(I_mem_wr_en), .I_mem_addr(I_mem_addr),
    .I_mem_wdata(I_mem_wdata), .I_mem_wstrb(I_mem_wstrb), .I_mem_rstrb(I_mem_rstrb),
    .O_mem_ready(O_mem_ready), .O_mem_rvalid(O_mem_rvalid), .O_mem_bvalid(O_mem_bvalid),
    .O_mem_rdata(O_mem_rdata),
    .O_bus_rd_en(O_bus_rd_en), .O_bus_wr_en(O_bus_wr_en), .O_bus_addr(O_bus_addr),
    .O_bus_wdata(O_bus_wdata), .O_bus_wstrb(O_bus_wstrb), .O_bus_rstrb(O_bus_rstrb),
    .I_bus_ready(I_bus_ready), .I_bus_rvalid(I_bus_rvalid), .I_bus_rdata(I_bus_rdata),
    .I_bus_bvalid(I_bus_bvalid)
  );

  initial I_sys_clk = 1'b0;
  always #5 I_sys_clk = ~I_sys_clk;

  task automatic step;
    @(posedge I_sys_clk);
    #1;
  endtask

  task automatic test_reset;
    I_rst = 1'b1;
    I_if_rd_en = 0; I_if_addr = 0;
    I_mem_rd_en = 0; I_mem_wr_en = 0; I_mem_addr = 0; I_mem_wdata = 0;
    I_mem_wstrb = 0; I_mem_rstrb = 0;
    I_bus_ready = 0; I_bus_rvalid = 0; I_bus_bvalid = 0; I_bus_rdata = 0;
    step; step; #1;
    checks++; if ({O_bus_rd_en, O_bus_wr_en, O_if_ready, O_mem_ready} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {O_bus_rd_en, O_bus_wr_en, O_if_ready, O_mem_ready}); end
    checks++; if ({O_if_rvalid, O_mem_rvalid, O_mem_bvalid} !== 3'b0) begin failures++; $display("FAIL reset_resp got=%b exp=000", {O_if_rvalid, O_mem_rvalid, O_mem_bvalid}); end
    checks++; if (O_bus_addr !== 32'h0 || O_bus_rstrb !== 9'h0) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", O_bus_addr, O_bus_rstrb); end
    I_rst = 1'b0;
  endtask

  task automatic test_if_read;
    I_if_rd_en = 1; I_if_addr = 32'h8000_0000;
    step; I_bus_ready = 1; #1;
    checks++; if (O_bus_rd_en !== 1'b1 || O_bus_addr !== 32'h8000_0000) begin failures++; $display("FAIL if_bus got=%b/%h exp=1/80000000", O_bus_rd_en, O_bus_addr); end
    checks++; if (O_bus_rstrb !== 9'h00F) begin failures++; $display("FAIL if_rstrb got=%h exp=00f", O_bus_rstrb); end
    checks++; if (O_if_ready !== 1'b1 || O_mem_ready !== 1'b0) begin failures++; $display("FAIL if_ready got=%b/%b exp=1/0", O_if_ready, O_mem_ready); end
    step; I_if_rd_en = 0; I_bus_ready = 0; #1;
    checks++; if (O_bus_rd_en !== 1'b0 || O_if_ready !== 1'b0) begin failures++; $display("FAIL if_resp_wait got=%b/%b exp=0/0", O_bus_rd_en, O_if_ready); end
    step; I_bus_rvalid = 1; I_bus_rdata = 64'h1234; #1;
    checks++; if (O_if_rvalid !== 1'b1 || O_if_rdata !== 64'h1234) begin failures++; $display("FAIL if_rvalid got=%b/%h exp=1/1234", O_if_rvalid, O_if_rdata); end
    checks++; if ({O_mem_rvalid, O_mem_bvalid} !== 2'b0 || O_mem_rdata !== 64'h0) begin failures++; $display("FAIL if_mem_quiet got=%b/%h exp=00/0", {O_mem_rvalid, O_mem_bvalid}, O_mem_rdata); end
    step; I_bus_rvalid = 0; I_bus_rdata = 0;
  endtask

  task automatic test_priority;
    I_if_rd_en = 1; I_if_addr = 32'h8000_0010;
    I_mem_rd_en = 1; I_mem_addr = 32'h0000_0100; I_mem_rstrb = 9'h0FF;
    step; I_bus_ready = 1; #1;
    checks++; if (O_bus_addr !== 32'h100 || O_bus_rstrb !== 9'h0FF) begin failures++; $display("FAIL prio_mem_bus got=%h/%h exp=100/0ff", O_bus_addr, O_bus_rstrb); end
    checks++; if (O_mem_ready !== 1'b1 || O_if_ready !== 1'b0) begin failures++; $display("FAIL prio_mem_ready got=%b/%b exp=1/0", O_mem_ready, O_if_ready); end
    step; I_mem_rd_en = 0; I_bus_ready = 0; I_bus_rvalid = 1; I_bus_rdata = 64'h55; #1;
    checks++; if (O_mem_rvalid !== 1'b1 || O_mem_rdata !== 64'h55 || O_if_rvalid !== 1'b0) begin failures++; $display("FAIL prio_mem_rvalid got=%b/%h/%b exp=1/55/0", O_mem_rvalid, O_mem_rdata, O_if_rvalid); end
    step; I_bus_rvalid = 0; #1;
    checks++; if (O_bus_rd_en !== 1'b0) begin failures++; $display("FAIL prio_idle_gap got=%b exp=0", O_bus_rd_en); end
    step; I_bus_ready = 1; #1;
    checks++; if (O_bus_addr !== 32'h8000_0010 || O_if_ready !== 1'b1) begin failures++; $display("FAIL prio_if_next got=%h/%b exp=80000010/1", O_bus_addr, O_if_ready); end
    step; I_if_rd_en = 0; I_bus_ready = 0; I_bus_rvalid = 1; I_bus_rdata = 64'h77; #1;
    checks++; if (O_if_rvalid !== 1'b1 || O_if_rdata !== 64'h77) begin failures++; $display("FAIL prio_if_rvalid got=%b/%h exp=1/77", O_if_rvalid, O_if_rdata); end
    step; I_bus_rvalid = 0;
  endtask

  task automatic test_store_wait;
    I_bus_rvalid = 1; I_bus_rdata = 64'hBAD; #1;
    checks++; if ({O_if_rvalid, O_mem_rvalid} !== 2'b0 || O_mem_rdata !== 64'h0) begin failures++; $display("FAIL idle_spurious got=%b/%h exp=00/0", {O_if_rvalid, O_mem_rvalid}, O_mem_rdata); end
    step; I_bus_rvalid = 0;
    I_mem_wr_en = 1; I_mem_rd_en = 1; I_mem_addr = 32'h200;
    I_mem_wdata = 64'hAAAA_AAAA_AAAA_AAAA; I_mem_wstrb = 8'hF0;
    for (int c = 1; c <= 3; c++) begin
      step;
      checks++; if (O_bus_wr_en !== 1'b1 || O_bus_rd_en !== 1'b0 || O_bus_addr !== 32'h200 || O_bus_wdata !== 64'hAAAA_AAAA_AAAA_AAAA || O_bus_wstrb !== 8'hF0 || O_mem_ready !== 1'b0) begin
        failures++; $display("FAIL store_hold c=%0d got=%b%b/%h/%h/%h/%b", c, O_bus_wr_en, O_bus_rd_en, O_bus_addr, O_bus_wdata, O_bus_wstrb, O_mem_ready);
      end
    end
    step; I_bus_ready = 1; #1;
    checks++; if (O_mem_ready !== 1'b1 || O_bus_wr_en !== 1'b1) begin failures++; $display("FAIL store_ready got=%b/%b exp=1/1", O_mem_ready, O_bus_wr_en); end
    step; I_mem_wr_en = 0; I_mem_rd_en = 0; I_bus_ready = 0; I_bus_rvalid = 1; #1;
    checks++; if ({O_mem_rvalid, O_if_rvalid, O_mem_bvalid, O_bus_wr_en} !== 4'b0) begin failures++; $display("FAIL store_wrong_resp got=%b exp=0000", {O_mem_rvalid, O_if_rvalid, O_mem_bvalid, O_bus_wr_en}); end
    step; I_bus_rvalid = 0; I_bus_bvalid = 1; #1;
    checks++; if (O_mem_bvalid !== 1'b1) begin failures++; $display("FAIL store_bvalid got=%b exp=1", O_mem_bvalid); end
    step; I_bus_bvalid = 1; #1;
    checks++; if (O_mem_bvalid !== 1'b0) begin failures++; $display("FAIL idle_bvalid_drop got=%b exp=0", O_mem_bvalid); end
    I_bus_bvalid = 0;
  endtask

  task automatic test_starvation;
    logic exp_if [6];
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    I_if_rd_en = 1; I_if_addr = 32'h8000_0040;
    I_mem_rd_en = 1; I_mem_addr = 32'h300; I_mem_rstrb = 9'h003;
    for (int g = 0; g < 6; g++) begin
      step; I_bus_ready = 1; #1;
      checks++; if (O_if_ready !== exp_if[g] || O_mem_ready !== !exp_if[g]) begin failures++; $display("FAIL starve_grant g=%0d got if/mem=%b/%b exp if=%b", g, O_if_ready, O_mem_ready, exp_if[g]); end
      step; I_bus_ready = 0; I_bus_rvalid = 1; I_bus_rdata = 64'(g); #1;
      step; I_bus_rvalid = 0;
    end
    I_if_rd_en = 0; I_mem_rd_en = 0;
  endtask

  task automatic test_reset_mid;
    step; I_mem_rd_en = 1; I_mem_addr = 32'h400;
    step; I_bus_ready = 1; #1;
    checks++; if (O_mem_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", O_mem_ready); end
    step; I_bus_ready = 0; I_mem_rd_en = 0; I_rst = 1;
    step; I_rst = 0; I_bus_rvalid = 1; I_bus_rdata = 64'hDEAD; #1;
    checks++; if ({O_mem_rvalid, O_if_rvalid, O_bus_rd_en, O_mem_ready} !== 4'b0 || O_mem_rdata !== 64'h0) begin failures++; $display("FAIL rst_mid_drop got=%b/%h exp=0000/0", {O_mem_rvalid, O_if_rvalid, O_bus_rd_en, O_mem_ready}, O_mem_rdata); end
    step; I_bus_rvalid = 0; I_if_rd_en = 1; I_if_addr = 32'h8000_0080;
    step; I_bus_ready = 1; #1;
    checks++; if (O_if_ready !== 1'b1 || O_bus_addr !== 32'h8000_0080) begin failures++; $display("FAIL rst_after_ready got=%b/%h exp=1/80000080", O_if_ready, O_bus_addr); end
    step; I_bus_ready = 0; I_if_rd_en = 0; I_bus_rvalid = 1; I_bus_rdata = 64'hCAFE; #1;
    checks++; if (O_if_rvalid !== 1'b1 || O_if_rdata !== 64'hCAFE) begin failures++; $display("FAIL rst_after_rvalid got=%b/%h exp=1/cafe", O_if_rvalid, O_if_rdata); end
    step; I_bus_rvalid = 0;
  endtask

  initial begin
    test_reset;
    test_if_read;
    test_priority;
    test_store_wait;
    test_starvation;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
